imem_loadable: RTL

- Parametrised successor to the fixed-content instruction ROM.
- Instruction memory whose contents are streamed in at run time through a valid/ready load port, not hard-coded at elaboration.
- Registered fetch port with one-cycle latency.
- Sits between the boot/test harness (load side) and the processor fetch stage (fetch side). Fetches beyond the loaded program return a programmable NOP word and flag an error.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_loadable_if.sv | 37 +++
 rtl/imem_sp_ram.sv | 31 +++
 rtl/imem_loadable.sv | 129 ++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   - default geometry and NOP word
//   - controller state encoding
//   - helper for the RAM index width
package imem_pkg;

    localparam int unsigned IMEM_DATA_W   = 32;
    localparam int unsigned IMEM_ADDR_W   = 8;
    localparam int unsigned IMEM_DEPTH    = 256;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_e;

    // Index width for a DEPTH-entry array; a single-entry array still needs one bit.
    function automatic int unsigned imem_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Load and fetch bus of the loadable instruction memory.
//   master : boot/test harness and fetch stage (drive requests, observe results)
//   slave  : imem_loadable
// Load side : load_start, load_valid, load_data, load_last -> load_ready, load_done,
//             word_count, busy
// Fetch side: fetch_en, fetch_addr -> fetch_data, fetch_valid, fetch_err
interface imem_loadable_if
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              fetch_err;
    logic              busy;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        input  load_ready, load_done, word_count, fetch_data, fetch_valid, fetch_err, busy
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        output load_ready, load_done, word_count, fetch_data, fetch_valid, fetch_err, busy
    );

endinterface

// File: rtl/imem_sp_ram.sv
// Single-write-port RAM with registered read, DATA_W x DEPTH.
//   clk   : write and read clock
//   we    : write enable, writes wdata to mem[waddr]
//   re    : read enable, rdata <= mem[raddr]; rdata holds while re is low
// Contents and rdata are not reset.
module imem_sp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory loaded at run time over a valid/ready stream, with a
// registered one-cycle fetch port.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : imem_loadable_if slave modport (load stream, fetch port, status)
// A load runs from load_start until the beat with load_last or the beat that
// fills the last word. Fetches are only served in RUN; anything beyond the
// loaded program returns NOP_WORD with fetch_err.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W   = IMEM_DATA_W,
    parameter int unsigned       ADDR_W   = IMEM_ADDR_W,
    parameter int unsigned       DEPTH    = IMEM_DEPTH,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
    input logic           clk,
    input logic           rst_n,
    imem_loadable_if.slave bus
);

    localparam int unsigned AW = imem_idx_w(DEPTH);
    localparam int unsigned CW = ADDR_W + 1;

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("imem_loadable: DEPTH must be in 1..2**ADDR_W");
    end

    imem_state_e       state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q;
    logic              done_q, done_d;
    logic              fvalid_q, fvalid_d;
    logic              ferr_q, ferr_d;
    logic              use_ram_q, use_ram_d;
    logic              accept;
    logic              last_beat;
    logic              in_range;
    logic              rd_en;
    logic [DATA_W-1:0] ram_rdata;

    // ready_q is only ever high in LOAD, so it doubles as the state qualifier.
    assign accept    = bus.load_valid & ready_q;
    assign last_beat = bus.load_last | (wptr_q == AW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wptr_d = wptr_q + AW'(1);
                    if (last_beat) begin
                        state_d = RUN;
                        count_d = CW'(wptr_q) + CW'(1);
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch decision uses the current state and count, so a fetch alongside
    // load_start sees the old program and one alongside the final beat is blocked.
    assign in_range = ({1'b0, bus.fetch_addr} < count_q);
    assign rd_en    = bus.fetch_en & (state_q == RUN) & in_range;

    always_comb begin
        fvalid_d  = bus.fetch_en & (state_q == RUN);
        ferr_d    = bus.fetch_en & ~rd_en;
        // Selector only moves on a fetch, so fetch_data holds when idle.
        use_ram_d = bus.fetch_en ? rd_en : use_ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            fvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            use_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            ready_q   <= (state_d == LOAD);
            done_q    <= done_d;
            fvalid_q  <= fvalid_d;
            ferr_q    <= ferr_d;
            use_ram_q <= use_ram_d;
        end
    end

    imem_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (bus.load_data),
        .re    (rd_en),
        .raddr (bus.fetch_addr[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.load_ready  = ready_q;
    assign bus.busy        = ready_q;
    assign bus.load_done   = done_q;
    assign bus.word_count  = count_q;
    assign bus.fetch_valid = fvalid_q;
    assign bus.fetch_err   = ferr_q;
    assign bus.fetch_data  = use_ram_q ? ram_rdata : NOP_WORD;

endmodule
